// File: rtl/des_search_pkg.sv
// Shared types and constants for the DES key-search result stage.
package des_search_pkg;

    localparam int DES_KEY_W = 56;
    localparam int DES_LANES = 28;

    typedef enum logic [1:0] {IDLE, SEARCH, FOUND, EXHAUSTED} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

endpackage

// File: rtl/hex_seg7.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_seg7 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h0E;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/des_hit_capture.sv
// Aligns lane match vectors with their base key, captures the first winning key,
// halts the search and pages the 56-bit result over six 7-segment digits.
module des_hit_capture
    import des_search_pkg::*;
#(
    parameter int LANES   = DES_LANES,
    parameter int LATENCY = 17,
    parameter int KEY_W   = DES_KEY_W
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             issue_valid,
    input  logic [KEY_W-1:0] key_base,
    input  logic [LANES-1:0] match,
    input  logic             page_next,
    output logic             halt,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] found_key,
    output logic [4:0]       found_lane,
    output logic [1:0]       page,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    // Any batch starting at or above this base covers key 2^KEY_W-1.
    localparam logic [KEY_W-1:0] LAST_BASE = {KEY_W{1'b1}} - KEY_W'(LANES - 1);

    logic [LATENCY-1:0]            vld_pipe;
    logic [LATENCY-1:0][KEY_W-1:0] key_pipe;
    logic                          d_valid;
    logic [KEY_W-1:0]              d_base;

    state_t           state_q, state_d;
    logic             hit_any, last_batch;
    logic [4:0]       hit_idx;
    logic             page_next_q;
    logic [KEY_W-1:0] disp_src;
    logic [5:0][3:0]  nib;
    logic [5:0]       ovr_en;
    logic [5:0][6:0]  ovr_seg, seg_raw, hex_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            vld_pipe <= '0;
            key_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue_valid;
            key_pipe[0] <= key_base;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                key_pipe[i] <= key_pipe[i-1];
            end
        end
    end

    assign d_valid    = vld_pipe[LATENCY-1];
    assign d_base     = key_pipe[LATENCY-1];
    assign hit_any    = |match;
    assign last_batch = (d_base >= LAST_BASE);

    // Lowest-index lane wins: scan downward so the last assignment is the lowest.
    always_comb begin
        hit_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = 5'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (issue_valid) state_d = SEARCH;
            SEARCH: begin
                if (d_valid && hit_any)         state_d = FOUND;
                else if (d_valid && last_batch) state_d = EXHAUSTED;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            halt       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            found_lane <= '0;
        end else begin
            state_q   <= state_d;
            halt      <= (state_d == FOUND) || (state_d == EXHAUSTED);
            found     <= (state_d == FOUND);
            exhausted <= (state_d == EXHAUSTED);
            if (state_q == SEARCH && state_d == FOUND) begin
                found_key  <= d_base + KEY_W'(hit_idx);
                found_lane <= hit_idx;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            page_next_q <= 1'b0;
            page        <= 2'd0;
        end else begin
            page_next_q <= page_next;
            if (page_next && !page_next_q) page <= (page == 2'd2) ? 2'd0 : page + 2'd1;
        end
    end

    always_comb begin
        case (state_q)
            FOUND:     disp_src = found_key;
            EXHAUSTED: disp_src = {KEY_W{1'b1}};
            default:   disp_src = d_base;
        endcase
    end

    always_comb begin
        nib     = '0;
        ovr_en  = '0;
        ovr_seg = {6{SEG_BLANK}};
        case (page)
            2'd0: for (int i = 0; i < 6; i++) nib[i] = disp_src[4*i +: 4];
            2'd1: for (int i = 0; i < 6; i++) nib[i] = disp_src[24 + 4*i +: 4];
            2'd2: begin
                nib[5]     = disp_src[KEY_W-1 -: 4];
                nib[4]     = disp_src[KEY_W-5 -: 4];
                ovr_en[3]  = 1'b1;
                nib[2]     = (state_q == FOUND) ? 4'hF : 4'hE;
                ovr_en[2]  = (state_q != FOUND) && (state_q != EXHAUSTED);
                ovr_seg[2] = SEG_DASH;
                nib[1]     = {3'b000, found_lane[4]};
                nib[0]     = found_lane[3:0];
            end
            default: ovr_en = '1;
        endcase
    end

    generate
        for (genvar g = 0; g < 6; g++) begin : g_seg
            hex_seg7 u_seg (
                .nib (nib[g]),
                .seg (seg_raw[g])
            );
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hex_q <= {6{SEG_ZERO}};
        end else begin
            for (int i = 0; i < 6; i++) hex_q[i] <= ovr_en[i] ? ovr_seg[i] : seg_raw[i];
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_des_hit_capture.sv
// Directed + randomized bench for des_hit_capture against a queue-based reference model.
module tb_des_hit_capture;

    localparam int L  = 17;
    localparam int LN = 28;
    localparam int KW = 56;

    logic          CLOCK_50 = 1'b0;
    logic          RESET;
    logic          issue_valid;
    logic [KW-1:0] key_base;
    logic [LN-1:0] match;
    logic          page_next;
    logic          halt, found, exhausted;
    logic [KW-1:0] found_key;
    logic [4:0]    found_lane;
    logic [1:0]    page;
    logic [6:0]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    always #5 CLOCK_50 = ~CLOCK_50;

    des_hit_capture #(.LANES(LN), .LATENCY(L), .KEY_W(KW)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .issue_valid(issue_valid), .key_base(key_base),
        .match(match), .page_next(page_next), .halt(halt), .found(found),
        .exhausted(exhausted), .found_key(found_key), .found_lane(found_lane), .page(page),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    typedef struct packed { logic v; logic [KW-1:0] b; } iss_t;

    iss_t       q[$];
    bit         m_started, m_found, m_exh, m_pn_prev;
    logic [KW-1:0] m_key;
    int         m_lane, m_page;
    logic [6:0] m_hex [6];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("halt", 64'(halt), 64'(m_found | m_exh));
        chk("found", 64'(found), 64'(m_found));
        chk("exhausted", 64'(exhausted), 64'(m_exh));
        chk("found_key", 64'(found_key), 64'(m_key));
        chk("found_lane", 64'(found_lane), 64'(m_lane));
        chk("page", 64'(page), 64'(m_page));
        chk("HEX0", 64'(HEX0), 64'(m_hex[0]));
        chk("HEX1", 64'(HEX1), 64'(m_hex[1]));
        chk("HEX2", 64'(HEX2), 64'(m_hex[2]));
        chk("HEX3", 64'(HEX3), 64'(m_hex[3]));
        chk("HEX4", 64'(HEX4), 64'(m_hex[4]));
        chk("HEX5", 64'(HEX5), 64'(m_hex[5]));
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < L; i++) q.push_back('0);
        m_started = 0; m_found = 0; m_exh = 0; m_pn_prev = 0;
        m_key = '0; m_lane = 0; m_page = 0;
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h40;
    endtask

    // One clock edge of the expected behaviour, using the values presented before the edge.
    task automatic model_edge(input logic iv, input logic [KW-1:0] kb, input logic [LN-1:0] m,
                              input logic pn);
        iss_t d;
        logic [KW-1:0] src;
        int j;
        d = q.pop_front();
        q.push_back({iv, kb});
        src = m_found ? m_key : (m_exh ? {KW{1'b1}} : d.b);
        if (m_page < 2) begin
            for (int i = 0; i < 6; i++) m_hex[i] = seg7(4'(src >> (24*m_page + 4*i)));
        end else begin
            m_hex[5] = seg7(4'(src >> 52));
            m_hex[4] = seg7(4'(src >> 48));
            m_hex[3] = 7'h7F;
            m_hex[2] = m_found ? seg7(4'hF) : (m_exh ? seg7(4'hE) : 7'h3F);
            m_hex[1] = seg7(4'(m_lane / 16));
            m_hex[0] = seg7(4'(m_lane % 16));
        end
        if (!m_started) begin
            m_started = iv;
        end else if (!m_found && !m_exh && d.v) begin
            if (m != 0) begin
                j = 0;
                while (!m[j]) j++;
                m_found = 1;
                m_lane  = j;
                m_key   = d.b + KW'(j);
            end else if ({8'd0, d.b} + 64'd28 >= 64'h0100_0000_0000_0000) begin
                m_exh = 1;
            end
        end
        if (pn && !m_pn_prev) m_page = (m_page + 1) % 3;
        m_pn_prev = pn;
    endtask

    task automatic step(input logic iv, input logic [KW-1:0] kb, input logic [LN-1:0] m,
                        input logic pn);
        issue_valid = iv; key_base = kb; match = m; page_next = pn;
        @(posedge CLOCK_50);
        model_edge(iv, kb, m, pn);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset();
        #2;
        issue_valid = 0; key_base = '0; match = '0; page_next = 0;
        RESET = 1;
        #1;
        model_reset();
        check_all();
        @(posedge CLOCK_50);
        #1;
        RESET = 0;
    endtask

    function automatic logic [LN-1:0] rnd_nz();
        return LN'($urandom) | (LN'(1) << $urandom_range(0, LN-1));
    endfunction

    // Issue nb consecutive batches; batch hb (if >=0) gets match vector hv L cycles later.
    task automatic run_search(input logic [KW-1:0] base, input int nb, input int hb,
                              input logic [LN-1:0] hv, input bit rnd_pn, input bit junk);
        logic iv;
        logic [KW-1:0] kb;
        logic [LN-1:0] m;
        logic pn;
        int j;
        for (int c = 0; c < nb + L + 4; c++) begin
            iv = (c < nb);
            kb = iv ? base + KW'(LN * c) : {24'($urandom), 32'($urandom)};
            j  = c - L;
            m  = '0;
            if (j < 0 || j >= nb) m = junk ? LN'($urandom) : '0;
            else if (j == hb) m = hv;
            else if (hb >= 0 && j > hb && junk) m = rnd_nz();
            pn = rnd_pn ? 1'($urandom_range(0, 1)) : 1'b0;
            step(iv, kb, m, pn);
        end
    endtask

    initial begin
        logic [KW-1:0] b;
        int nb, hb;
        RESET = 1; issue_valid = 0; key_base = '0; match = '0; page_next = 0;
        @(posedge CLOCK_50);
        #1;
        model_reset();
        check_all();
        RESET = 0;

        // Plain counting search, no hits.
        run_search(56'd0, 30, -1, '0, 0, 0);

        do_reset();
        run_search(56'h1C0, 1, 0, LN'(1) << 5, 0, 1);
        chk("hit5_key", 64'(found_key), 64'h1C5);
        chk("hit5_lane", 64'(found_lane), 64'd5);

        do_reset();
        run_search(56'h1C0, 4, 2, (LN'(1) << 3) | (LN'(1) << 9), 0, 1);
        chk("hit39_key", 64'(found_key), 64'h1C0 + 64'd56 + 64'd3);

        // Run into the top of the key space with no hit.
        do_reset();
        run_search(56'hFF_FFFF_FFFF_FFAC, 3, -1, '0, 0, 0);
        chk("exh_flag", 64'(exhausted), 64'd1);
        step(0, '0, '0, 1); step(0, '0, '0, 0); step(0, '0, '0, 1); step(0, '0, '0, 0);
        chk("exh_hex2", 64'(HEX2), 64'h06);

        do_reset();
        run_search(56'hFF_FFFF_FFFF_FFE4, 1, 0, LN'(1) << 27, 0, 0);
        chk("top_key", 64'(found_key), 64'h00FF_FFFF_FFFF_FFFF);
        chk("top_exh", 64'(exhausted), 64'd0);

        // Randomized searches with page toggling and stray match pulses.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            b  = ($urandom_range(0, 3) == 0) ? 56'hFF_FFFF_FFFF_FF00 + KW'($urandom_range(0, 255))
                                             : {24'($urandom), 32'($urandom)};
            nb = $urandom_range(1, 12);
            hb = $urandom_range(0, nb);
            if (hb == nb) hb = -1;
            run_search(b, nb, hb, rnd_nz() & (LN'($urandom) | (LN'(1) << $urandom_range(0, LN-1))), 1, 1);
        end

        // Display paging on a known key.
        do_reset();
        run_search(56'h12_3456_789A_BCDE - 56'd13, 1, 0, LN'(1) << 13, 0, 0);
        step(0, '0, '0, 1); step(0, '0, '0, 0);
        chk("p1_hex5", 64'(HEX5), 64'h30);
        chk("p1_hex0", 64'(HEX0), 64'h00);
        step(0, '0, '0, 1); step(0, '0, '0, 0);
        chk("p2_hex5", 64'(HEX5), 64'h79);
        chk("p2_hex2", 64'(HEX2), 64'h0E);
        chk("p2_hex0", 64'(HEX0), 64'h21);
        step(0, '0, '0, 1); step(0, '0, '0, 0);
        chk("p0_page", 64'(page), 64'd0);
        do_reset();
        chk("rst_found", 64'(found), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
